bitcrush_decimate: RTL and testbench

- Successor to the single-mask bit crusher, generalised to N_CH audio channels.
- Bit depth is CV-controlled and set by parameters; adds CV-controlled sample-rate reduction (sample-and-hold) and a selectable truncate or round quantiser.
- Processes channels serially, one per clk, after each sample strobe.
- Sits between the codec sample path and the jack outputs.

---
 rtl/bitcrush_decimate.sv | 118 +++++++++++
 tb/tb_bitcrush_decimate.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/bitcrush_decimate.sv
// Multi-channel bit crusher with CV-controlled depth, sample-and-hold decimation
// and truncate/round quantisation; channels are processed serially after each strobe.
module bitcrush_decimate #(
  parameter int W           = 16,
  parameter int N_CH        = 3,
  parameter int MIN_BITS    = 2,
  parameter int DEPTH_SHIFT = 10,
  parameter int HOLD_W      = 6,
  parameter int RATE_SHIFT  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              strobe_in,
  input  logic [W-1:0]      cv_depth,
  input  logic [W-1:0]      cv_rate,
  input  logic [1:0]        mode,
  input  logic [N_CH*W-1:0] sample_in,
  output logic [N_CH*W-1:0] sample_out,
  output logic              strobe_out,
  output logic              overrun
);

  localparam int BITS_W = $clog2(W + 1);
  localparam int IDX_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = '1;
  localparam logic [W:0]   MAX_POS   = (W+1)'((1 << (W - 1)) - 1);
  localparam logic [W-1:0] MAX_POS_W = MAX_POS[W-1:0];

  // Handshake: strobe_in is a one-clk valid with no ready; it is accepted only
  // in IDLE, otherwise dropped and flagged on overrun. strobe_out is a one-clk
  // valid qualifying the whole sample_out word.
  typedef enum logic [1:0] {IDLE, PROC, DONE} state_t;

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    idx;
  logic [HOLD_W-1:0]   cnt;
  logic [N_CH*W-1:0]   cap_samples;
  logic [BITS_W-1:0]   cap_bits;
  logic [1:0]          cap_mode;

  logic [W-1:0]        cvd_pos, cvr_pos, cvr_shift;
  logic [W:0]          bits_sum;
  logic [BITS_W-1:0]   bits_new;
  logic [HOLD_W-1:0]   hold_new;

  always_comb begin
    cvd_pos   = cv_depth[W-1] ? '0 : cv_depth;
    cvr_pos   = cv_rate[W-1] ? '0 : cv_rate;
    bits_sum  = {1'b0, cvd_pos >> DEPTH_SHIFT} + (W+1)'(MIN_BITS);
    bits_new  = (bits_sum > (W+1)'(W)) ? BITS_W'(W) : BITS_W'(bits_sum);
    cvr_shift = cvr_pos >> RATE_SHIFT;
    hold_new  = (cvr_shift > W'(HOLD_MAX)) ? HOLD_MAX : HOLD_W'(cvr_shift);
  end

  logic [W-1:0] x_sel, mask, half, y;
  logic [W:0]   s;

  // Quantiser for the channel currently selected by idx.
  always_comb begin
    x_sel = cap_samples[idx*W +: W];
    mask  = {W{1'b1}} << (W - cap_bits);
    half  = '0;
    if (cap_bits < BITS_W'(W)) half = W'(1) << (W - 1 - cap_bits);
    s = {x_sel[W-1], x_sel} + {1'b0, half};
    y = x_sel;
    if (cap_mode == 2'b00) begin
      y = x_sel & mask;
    end else if (cap_mode == 2'b01 && cap_bits < BITS_W'(W)) begin
      if ($signed(s) > $signed(MAX_POS)) y = MAX_POS_W & mask;
      else                               y = s[W-1:0] & mask;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (strobe_in) state_nxt = PROC;
      PROC:    if (idx == IDX_W'(N_CH - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign strobe_out = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      cnt         <= '0;
      cap_samples <= '0;
      cap_bits    <= BITS_W'(MIN_BITS);
      cap_mode    <= '0;
      sample_out  <= '0;
      overrun     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (strobe_in && state != IDLE) overrun <= 1'b1;
      if (state == IDLE && strobe_in) begin
        idx <= '0;
        // A held frame re-runs the old capture, so sample_out is rewritten unchanged.
        if (cnt == '0) begin
          cap_samples <= sample_in;
          cap_bits    <= bits_new;
          cap_mode    <= mode;
          cnt         <= hold_new;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
      if (state == PROC) begin
        sample_out[idx*W +: W] <= y;
        idx                    <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bitcrush_decimate.sv
// Directed bench for bitcrush_decimate: expected frames are queued at strobe time
// and compared (with latency) whenever strobe_out fires.
module tb_bitcrush_decimate;

  localparam int W = 16, N_CH = 3, MIN_BITS = 2, DEPTH_SHIFT = 10;
  localparam int HOLD_W = 6, RATE_SHIFT = 8;
  localparam int PW = N_CH * W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          strobe_in = 1'b0;
  logic [W-1:0]  cv_depth = '0;
  logic [W-1:0]  cv_rate = '0;
  logic [1:0]    mode = '0;
  logic [PW-1:0] sample_in = '0;
  logic [PW-1:0] sample_out;
  logic          strobe_out;
  logic          overrun;

  bitcrush_decimate #(
    .W(W), .N_CH(N_CH), .MIN_BITS(MIN_BITS), .DEPTH_SHIFT(DEPTH_SHIFT),
    .HOLD_W(HOLD_W), .RATE_SHIFT(RATE_SHIFT)
  ) dut (
    .clk(clk), .rst(rst), .strobe_in(strobe_in), .cv_depth(cv_depth),
    .cv_rate(cv_rate), .mode(mode), .sample_in(sample_in),
    .sample_out(sample_out), .strobe_out(strobe_out), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  logic [PW-1:0] exp_q[$];
  int            lat_q[$];

  task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    strobe_in = 1'b1;
    tick();
    strobe_in = 1'b0;
  endtask

  task automatic send(input logic [PW-1:0] smp, input logic [PW-1:0] exp);
    sample_in = smp;
    exp_q.push_back(exp);
    lat_q.push_back(cyc);
    pulse();
    repeat (N_CH + 1) tick();
  endtask

  function automatic logic [PW-1:0] pack(input logic [W-1:0] c0, input logic [W-1:0] c1,
                                         input logic [W-1:0] c2);
    return {c2, c1, c0};
  endfunction

  function automatic int bits_ref(input logic [W-1:0] cv);
    int c, b;
    c = $signed(cv);
    if (c < 0) c = 0;
    b = MIN_BITS + (c >>> DEPTH_SHIFT);
    if (b > W) b = W;
    return b;
  endfunction

  function automatic int floor_mod(input int v, input int step);
    return ((v % step) + step) % step;
  endfunction

  // Arithmetic reference: quantise to multiples of 2^(W-bits).
  function automatic logic [W-1:0] quant_ref(input logic [W-1:0] x, input int bits,
                                             input logic [1:0] md);
    int xi, step, q, v, mx;
    logic [31:0] r;
    xi   = $signed(x);
    step = 1 << (W - bits);
    mx   = (1 << (W - 1)) - 1;
    q    = xi;
    if (md == 2'b00) begin
      q = xi - floor_mod(xi, step);
    end else if (md == 2'b01 && bits < W) begin
      v = xi + step / 2;
      q = v - floor_mod(v, step);
      if (v > mx) q = mx - floor_mod(mx, step);
    end
    r = q;
    return r[W-1:0];
  endfunction

  always @(negedge clk) begin
    if (!rst && strobe_out) begin
      n_vec++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_strobe: observed strobe_out=1 expected no strobe");
      end
      if (exp_q.size() != 0) begin
        logic [PW-1:0] e;
        int l;
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        check("sample_out", sample_out, e);
        check("latency", PW'(cyc - l), PW'(N_CH + 1));
      end
    end
  end

  initial begin
    logic [W-1:0] r0, r1, r2;
    logic [W-1:0] c0 [4];
    logic [W-1:0] e0 [4];
    int b;

    // Reset state
    repeat (3) tick();
    check("rst_sample_out", sample_out, '0);
    check("rst_strobe_out", PW'(strobe_out), '0);
    check("rst_overrun", PW'(overrun), '0);
    rst = 1'b0;
    tick();

    // Reset mid-frame aborts without strobe
    mode = 2'b10; cv_depth = '0; cv_rate = '0;
    sample_in = pack(16'h1111, 16'h2222, 16'h3333);
    pulse();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_sample_out", sample_out, '0);
    check("midrst_overrun", PW'(overrun), '0);
    check("midrst_strobe_out", PW'(strobe_out), '0);
    repeat (6) tick();

    // Truncate at 2 bits, then full depth
    mode = 2'b00; cv_depth = 16'd0; cv_rate = 16'd0;
    send(pack(16'h7FFF, 16'h1234, 16'hC001), pack(16'h4000, 16'h0000, 16'hC000));
    cv_depth = 16'd14336;
    send(pack(16'h8001, 16'h1234, 16'hC001), pack(16'h8001, 16'h1234, 16'hC001));
    cv_depth = 16'h7FFF;
    send(pack(16'h0001, 16'hFFFF, 16'h5A5A), pack(16'h0001, 16'hFFFF, 16'h5A5A));

    // Round at 8 bits
    mode = 2'b01; cv_depth = 16'd6144;
    c0[0] = 16'h0080; e0[0] = 16'h0100;
    c0[1] = 16'h007F; e0[1] = 16'h0000;
    c0[2] = 16'h7FC0; e0[2] = 16'h7F00;
    c0[3] = 16'hFF7F; e0[3] = 16'hFF00;
    for (int i = 0; i < 4; i++)
      send(pack(c0[i], 16'h1234, 16'hC001), pack(e0[i], 16'h1200, 16'hC000));

    // Random depth/mode with no hold, checked against the arithmetic reference
    cv_rate = 16'd0;
    for (int i = 0; i < 8; i++) begin
      mode     = 2'($urandom_range(0, 3));
      cv_depth = 16'($urandom_range(0, 65535));
      r0 = 16'($urandom_range(0, 65535));
      r1 = 16'($urandom_range(0, 65535));
      r2 = 16'($urandom_range(0, 65535));
      b  = bits_ref(cv_depth);
      send(pack(r0, r1, r2),
           pack(quant_ref(r0, b, mode), quant_ref(r1, b, mode), quant_ref(r2, b, mode)));
    end

    // Rate hold of 2 in bypass
    mode = 2'b10; cv_rate = 16'd512;
    for (int i = 1; i <= 6; i++)
      send(pack(16'(i), 16'h0000, 16'h0000),
           pack((i <= 3) ? 16'd1 : 16'd4, 16'h0000, 16'h0000));

    // Negative CVs clamp to 2 bits and no hold
    mode = 2'b00; cv_depth = 16'hFFFF; cv_rate = 16'h8000;
    send(pack(16'h3FFF, 16'h7FFF, 16'hBFFF), pack(16'h0000, 16'h4000, 16'h8000));
    mode = 2'b10; cv_depth = 16'h0000; cv_rate = 16'h0000;
    send(pack(16'h1111, 16'h2222, 16'h3333), pack(16'h1111, 16'h2222, 16'h3333));

    // Maximum hold: 64-sample period
    cv_rate = 16'h7FFF;
    send(pack(16'hAAAA, 16'hBBBB, 16'hCCCC), pack(16'hAAAA, 16'hBBBB, 16'hCCCC));
    cv_rate = 16'h0000;
    for (int i = 0; i < 63; i++)
      send(pack(16'($urandom_range(0, 65535)), 16'h0, 16'h0),
           pack(16'hAAAA, 16'hBBBB, 16'hCCCC));
    send(pack(16'h5555, 16'h6666, 16'h7777), pack(16'h5555, 16'h6666, 16'h7777));

    // Overrun: second strobe during PROC is dropped and the flag sticks
    check("ovr_before", PW'(overrun), '0);
    sample_in = pack(16'h0102, 16'h0304, 16'h0506);
    exp_q.push_back(pack(16'h0102, 16'h0304, 16'h0506));
    lat_q.push_back(cyc);
    pulse();
    tick();
    sample_in = pack(16'hDEAD, 16'hBEEF, 16'hCAFE);
    pulse();
    repeat (4) tick();
    check("ovr_set", PW'(overrun), 1);
    send(pack(16'h0A0A, 16'h0B0B, 16'h0C0C), pack(16'h0A0A, 16'h0B0B, 16'h0C0C));
    check("ovr_sticky", PW'(overrun), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("ovr_cleared", PW'(overrun), '0);

    // Drain with a bounded wait
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    check("drain_pending", PW'(exp_q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
